// File: rtl/l4_bt_pkg.sv
// Shared definitions for the L4 backtrace sequencer: direction codes, grid code
// layout, FSM encoding and error codes.
package l4_bt_pkg;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam int CODE_W = 3;
  localparam int MARK   = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EMIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } bt_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMARKED = 2'd1;
  localparam logic [1:0] ERR_OFFGRID  = 2'd2;
  localparam logic [1:0] ERR_LIMIT    = 2'd3;

  // True when stepping in dir from the current cell would leave the grid.
  function automatic logic step_off_grid(input logic [1:0] dir,
                                         input logic x_zero, input logic x_max,
                                         input logic y_zero, input logic y_max);
    logic off;
    off = 1'b0;
    case (dir)
      DIR_N:   off = y_max;
      DIR_E:   off = x_max;
      DIR_S:   off = y_zero;
      default: off = x_zero;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/l4_bt_coord.sv
// One backtrace coordinate register with load/inc/dec and grid-edge flags.
// Load wins over inc, inc wins over dec.
module l4_bt_coord #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] val,
  output logic         at_zero,
  output logic         at_max
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc) begin
      val_d = val_q + W'(1);
    end else if (dec) begin
      val_d = val_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val     = val_q;
  assign at_zero = (val_q == '0);
  assign at_max  = (val_q == '1);

endmodule

// File: rtl/l4_backtrace_ctrl.sv
// Backtrace sequencer: walks from target to source through the marked grid,
// reading one direction code per cell and emitting each cell to the path consumer.
module l4_backtrace_ctrl
  import l4_bt_pkg::*;
#(
  parameter int XBITS = 5,
  parameter int YBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [XBITS-1:0] src_x,
  input  logic [YBITS-1:0] src_y,
  input  logic [XBITS-1:0] tgt_x,
  input  logic [YBITS-1:0] tgt_y,
  output logic             mem_req,
  output logic [XBITS-1:0] mem_x,
  output logic [YBITS-1:0] mem_y,
  input  logic             mem_ack,
  input  logic [2:0]       mem_code,
  output logic             path_valid,
  input  logic             path_ready,
  output logic [XBITS-1:0] path_x,
  output logic [YBITS-1:0] path_y,
  output logic             path_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int CW = XBITS + YBITS;

  bt_state_e          state_q, state_d;
  logic [XBITS-1:0]   src_x_q, src_x_d;
  logic [YBITS-1:0]   src_y_q, src_y_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               mem_req_q, mem_req_d;
  logic               path_valid_q, path_valid_d;
  logic               path_last_q, path_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [XBITS-1:0]   cur_x, nxt_x;
  logic [YBITS-1:0]   cur_y, nxt_y;
  logic               x_zero, x_max, y_zero, y_max;
  logic               x_load, x_inc, x_dec;
  logic               y_load, y_inc, y_dec;
  logic [1:0]         step_dir;

  l4_bt_coord #(.W(XBITS)) u_coord_x (
    .clk      (clk),
    .reset    (reset),
    .load     (x_load),
    .load_val (tgt_x),
    .inc      (x_inc),
    .dec      (x_dec),
    .val      (cur_x),
    .at_zero  (x_zero),
    .at_max   (x_max)
  );

  l4_bt_coord #(.W(YBITS)) u_coord_y (
    .clk      (clk),
    .reset    (reset),
    .load     (y_load),
    .load_val (tgt_y),
    .inc      (y_inc),
    .dec      (y_dec),
    .val      (cur_y),
    .at_zero  (y_zero),
    .at_max   (y_max)
  );

  assign step_dir = code_q[1:0];

  // Coordinate after the pending step; used to skip the read of the source cell.
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    case (step_dir)
      DIR_N:   nxt_y = cur_y + YBITS'(1);
      DIR_E:   nxt_x = cur_x + XBITS'(1);
      DIR_S:   nxt_y = cur_y - YBITS'(1);
      default: nxt_x = cur_x - XBITS'(1);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    src_x_d      = src_x_q;
    src_y_d      = src_y_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    err_code_d   = err_code_q;
    mem_req_d    = mem_req_q;
    path_valid_d = path_valid_q;
    path_last_d  = path_last_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    x_load       = 1'b0;
    x_inc        = 1'b0;
    x_dec        = 1'b0;
    y_load       = 1'b0;
    y_inc        = 1'b0;
    y_dec        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_x_d    = src_x;
          src_y_d    = src_y;
          cnt_d      = '0;
          err_code_d = ERR_NONE;
          x_load     = 1'b1;
          y_load     = 1'b1;
          busy_d     = 1'b1;
          if (tgt_x == src_x && tgt_y == src_y) begin
            state_d      = ST_EMIT;
            path_valid_d = 1'b1;
            path_last_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            mem_req_d = 1'b1;
          end
        end
      end

      ST_READ: begin
        if (mem_ack) begin
          code_d       = mem_code;
          mem_req_d    = 1'b0;
          path_valid_d = 1'b1;
          path_last_d  = (cur_x == src_x_q) && (cur_y == src_y_q);
          state_d      = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (path_ready) begin
          path_valid_d = 1'b0;
          path_last_d  = 1'b0;
          if (path_last_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!code_q[MARK]) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_UNMARKED;
          end else if (step_off_grid(step_dir, x_zero, x_max, y_zero, y_max)) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_OFFGRID;
          end else if (cnt_q == '1) begin
            state_d    = ST_ERR;
            busy_d     = 1'b0;
            err_d      = 1'b1;
            err_code_d = ERR_LIMIT;
          end else begin
            cnt_d = cnt_q + CW'(1);
            x_inc = (step_dir == DIR_E);
            x_dec = (step_dir == DIR_W);
            y_inc = (step_dir == DIR_N);
            y_dec = (step_dir == DIR_S);
            if (nxt_x == src_x_q && nxt_y == src_y_q) begin
              state_d      = ST_EMIT;
              path_valid_d = 1'b1;
              path_last_d  = 1'b1;
            end else begin
              state_d   = ST_READ;
              mem_req_d = 1'b1;
            end
          end
        end
      end

      ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_x_q      <= '0;
      src_y_q      <= '0;
      cnt_q        <= '0;
      code_q       <= '0;
      err_code_q   <= ERR_NONE;
      mem_req_q    <= 1'b0;
      path_valid_q <= 1'b0;
      path_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_x_q      <= src_x_d;
      src_y_q      <= src_y_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      err_code_q   <= err_code_d;
      mem_req_q    <= mem_req_d;
      path_valid_q <= path_valid_d;
      path_last_q  <= path_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_x      = cur_x;
  assign mem_y      = cur_y;
  assign path_valid = path_valid_q;
  assign path_x     = cur_x;
  assign path_y     = cur_y;
  assign path_last  = path_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule
